// File: rtl/task_answer_arbiter.sv
// ---------------------------------------------------------------------------
// task_answer_arbiter
//
// Shares the single task-manager answer channel between NUM_TASKS task
// modules. A requesting task is granted round-robin, its answer stream and
// packet size are forwarded to the task manager until the last beat, then
// the channel is released through a one-cycle GAP state and the number of
// beats is checked against ceil(size/4).
//
// Optional feature macro: TASK_ARB_TIMEOUT_EN
//   defined   -> a stall counter aborts a packet after TIMEOUT_CYCLES cycles
//                without a beat and pulses o_timeout.
//   undefined -> no stall counter; o_timeout is tied to 0.
//
// Ports:
//   i_clk                    clock, rising edge
//   i_rst                    asynchronous active-low reset
//   i_task_answer_ready      per-task answer available / word valid
//   i_task_answer_data       per-task answer word, task k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_task_answer_data_last  per-task last-word flag
//   i_task_packet_size       per-task packet size in bytes
//   o_task_manager_ready     manager-ready forwarded to the granted task only
//   i_tmanager_ready         task manager accepts a word this cycle
//   o_tanswer_ready          forwarded answer valid
//   o_tanswer_data           forwarded answer word
//   o_tanswer_data_last      forwarded last flag
//   o_packet_size_in_bytes   packet size latched at grant
//   o_grant                  one-hot owner, zero when the channel is free
//   o_len_err                sticky beat-count mismatch flag
//   o_timeout                one-cycle pulse when a stalled packet is aborted
// ---------------------------------------------------------------------------
module task_answer_arbiter #(
  parameter int NUM_TASKS      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int SIZE_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_TASKS-1:0]             i_task_answer_ready,
  input  logic [NUM_TASKS*DATA_WIDTH-1:0]  i_task_answer_data,
  input  logic [NUM_TASKS-1:0]             i_task_answer_data_last,
  input  logic [NUM_TASKS*SIZE_WIDTH-1:0]  i_task_packet_size,
  output logic [NUM_TASKS-1:0]             o_task_manager_ready,
  input  logic                             i_tmanager_ready,
  output logic                             o_tanswer_ready,
  output logic [DATA_WIDTH-1:0]            o_tanswer_data,
  output logic                             o_tanswer_data_last,
  output logic [SIZE_WIDTH-1:0]            o_packet_size_in_bytes,
  output logic [NUM_TASKS-1:0]             o_grant,
  output logic                             o_len_err,
  output logic                             o_timeout
);

  localparam int IDX_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;

  // Elaboration-time parameter range checks.
  if ((NUM_TASKS < 2) || (NUM_TASKS > 8)) begin : g_num_tasks_check
    $error("task_answer_arbiter: NUM_TASKS must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("task_answer_arbiter: TIMEOUT_CYCLES must be at least 2");
  end
  if (SIZE_WIDTH < 3) begin : g_size_width_check
    $error("task_answer_arbiter: SIZE_WIDTH must be at least 3");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t                 state_q;
  logic [NUM_TASKS-1:0]   grant_q;
  logic [IDX_W-1:0]       gidx_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [SIZE_WIDTH-1:0]  size_q;
  logic [SIZE_WIDTH-1:0]  beat_q;
  logic                   len_err_q;

`ifdef TASK_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0]     stall_q;
  logic                   timeout_q;
`endif

  logic [IDX_W:0]         pick;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic                   beat;
  logic [SIZE_WIDTH-1:0]  beat_inc;
  logic [SIZE_WIDTH:0]    exp_beats;
  logic [IDX_W-1:0]       rr_ptr_d;

  // Round-robin pick: first requester at or after ptr, wrapping. Scanning the
  // offsets from the far end lets the nearest requester overwrite the result.
  // Returns {valid, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_TASKS-1:0] req,
                                             input logic [IDX_W-1:0]     ptr);
    logic [IDX_W:0] res;
    int             cand;
    res = '0;
    for (int i = NUM_TASKS - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_TASKS) begin
        cand = cand - NUM_TASKS;
      end else begin
        cand = cand;
      end
      if (req[cand[IDX_W-1:0]]) begin
        res = {1'b1, cand[IDX_W-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick       = rr_pick(i_task_answer_ready, rr_ptr_q);
  assign pick_valid = pick[IDX_W];
  assign pick_idx   = pick[IDX_W-1:0];

  // Beat counter saturates so a runaway packet cannot wrap back to a match.
  assign beat_inc  = (&beat_q) ? beat_q : beat_q + SIZE_WIDTH'(1);

  // ceil(size/4) computed one bit wider so size near full scale does not wrap.
  assign exp_beats = ({1'b0, size_q} + (SIZE_WIDTH + 1)'(3)) >> 2;

  assign rr_ptr_d  = (gidx_q == IDX_W'(NUM_TASKS - 1)) ? '0 : gidx_q + IDX_W'(1);

  // Forwarding mux: only the granted task reaches the manager, only in STREAM.
  always_comb begin
    o_tanswer_ready      = 1'b0;
    o_tanswer_data       = '0;
    o_tanswer_data_last  = 1'b0;
    o_task_manager_ready = '0;
    if (state_q == ST_STREAM) begin
      o_tanswer_ready              = i_task_answer_ready[gidx_q];
      o_tanswer_data               = i_task_answer_data[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
      o_tanswer_data_last          = i_task_answer_data_last[gidx_q];
      o_task_manager_ready[gidx_q] = i_tmanager_ready;
    end else begin
      o_tanswer_ready = 1'b0;
    end
  end

  assign beat = o_tanswer_ready & i_tmanager_ready;

  // Arbiter FSM with grant, size latch, beat counter, pointer and flags.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      size_q    <= '0;
      beat_q    <= '0;
      len_err_q <= 1'b0;
`ifdef TASK_ARB_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef TASK_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q <= NUM_TASKS'(1) << pick_idx;
            gidx_q  <= pick_idx;
            size_q  <= i_task_packet_size[int'(pick_idx)*SIZE_WIDTH +: SIZE_WIDTH];
            beat_q  <= '0;
            state_q <= ST_STREAM;
`ifdef TASK_ARB_TIMEOUT_EN
            stall_q <= '0;
`endif
          end else begin
            grant_q <= '0;
          end
        end

        ST_STREAM: begin
          if (beat) begin
            beat_q <= beat_inc;
            if (o_tanswer_data_last) begin
              // Count includes the last beat itself.
              if ({1'b0, beat_inc} != exp_beats) begin
                len_err_q <= 1'b1;
              end
              state_q <= ST_GAP;
            end
          end
`ifdef TASK_ARB_TIMEOUT_EN
          // Stall watchdog: counts cycles since the last accepted beat.
          if (beat) begin
            stall_q <= '0;
          end else if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= ST_GAP;
          end else begin
            stall_q <= stall_q + STALL_W'(1);
          end
`endif
        end

        ST_GAP: begin
          grant_q  <= '0;
          size_q   <= '0;
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ST_IDLE;
        end

        default: begin
          grant_q <= '0;
          size_q  <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_grant                = grant_q;
  assign o_packet_size_in_bytes = size_q;
  assign o_len_err              = len_err_q;

`ifdef TASK_ARB_TIMEOUT_EN
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_task_answer_arbiter.sv
module tb_task_answer_arbiter;

  localparam int NT = 4;
  localparam int DW = 32;
  localparam int SW = 12;

  logic              clk;
  logic              rst_n;
  logic [NT-1:0]     req;
  logic [NT*DW-1:0]  data;
  logic [NT-1:0]     last;
  logic [NT*SW-1:0]  size;
  logic [NT-1:0]     tmr_o;
  logic              tm_ready;
  logic              ans_ready;
  logic [DW-1:0]     ans_data;
  logic              ans_last;
  logic [SW-1:0]     pkt_size;
  logic [NT-1:0]     grant;
  logic              len_err;
  logic              timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          tsk;
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];

  task_answer_arbiter #(
    .NUM_TASKS(NT), .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk                  (clk),
    .i_rst                  (rst_n),
    .i_task_answer_ready    (req),
    .i_task_answer_data     (data),
    .i_task_answer_data_last(last),
    .i_task_packet_size     (size),
    .o_task_manager_ready   (tmr_o),
    .i_tmanager_ready       (tm_ready),
    .o_tanswer_ready        (ans_ready),
    .o_tanswer_data         (ans_data),
    .o_tanswer_data_last    (ans_last),
    .o_packet_size_in_bytes (pkt_size),
    .o_grant                (grant),
    .o_len_err              (len_err),
    .o_timeout              (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_task(input int k, input logic r, input logic [31:0] d,
                          input logic l, input logic [11:0] s);
    req[k]          = r;
    data[k*DW +: DW] = d;
    last[k]         = l;
    size[k*SW +: SW] = s;
  endtask

  task automatic push(input int k, input logic [31:0] d, input logic l);
    beat_t b;
    b.tsk = k;
    b.d   = d;
    b.l   = l;
    exp_q.push_back(b);
  endtask

  // Scoreboard monitor: every accepted beat must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && ans_ready && tm_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", {32'd0, ans_data}, 64'd0);
      end else begin
        beat_t e;
        logic [3:0] one;
        e   = exp_q.pop_front();
        one = 4'b0001;
        chk("sb_data",  {32'd0, ans_data}, {32'd0, e.d});
        chk("sb_last",  {63'd0, ans_last}, {63'd0, e.l});
        chk("sb_grant", {60'd0, grant},    {60'd0, one << e.tsk});
        chk("sb_tmr",   {60'd0, tmr_o},    {60'd0, one << e.tsk});
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    data     = '0;
    last     = '0;
    size     = '0;
    tm_ready = 1'b1;

    // ---- reset state
    tick();
    tick();
    chk("rst_grant",   {60'd0, grant},     64'd0);
    chk("rst_ready",   {63'd0, ans_ready}, 64'd0);
    chk("rst_tmr",     {60'd0, tmr_o},     64'd0);
    chk("rst_size",    {52'd0, pkt_size},  64'd0);
    chk("rst_len_err", {63'd0, len_err},   64'd0);
    chk("rst_timeout", {63'd0, timeout},   64'd0);
    rst_n = 1'b1;
    tick();

    // ---- round-robin: all tasks request 1-word packets of size 4
    for (int k = 0; k < NT; k++) set_task(k, 1'b1, 32'hB000_0000 + 32'(k), 1'b1, 12'd4);
    push(0, 32'hB000_0000, 1'b1);
    push(1, 32'hB000_0001, 1'b1);
    push(2, 32'hB000_0002, 1'b1);
    push(3, 32'hB000_0003, 1'b1);
    push(0, 32'hB000_0000, 1'b1);
    tick();
    for (int p = 0; p < 5; p++) begin
      logic [3:0] one;
      one = 4'b0001;
      chk("rr_grant", {60'd0, grant}, {60'd0, one << (p % NT)});
      chk("rr_valid", {63'd0, ans_ready}, 64'd1);
      tick();
      if (p == 4) req = '0;
      chk("rr_gap1", {63'd0, ans_ready}, 64'd0);
      tick();
      chk("rr_gap2", {63'd0, ans_ready}, 64'd0);
      tick();
    end
    chk("rr_free", {60'd0, grant}, 64'd0);
    chk("rr_len_err", {63'd0, len_err}, 64'd0);
    for (int k = 0; k < NT; k++) set_task(k, 1'b0, 32'd0, 1'b0, 12'd0);

    // ---- single task: task 1, size 8, two words
    set_task(1, 1'b1, 32'hA5A5_0001, 1'b0, 12'd8);
    push(1, 32'hA5A5_0001, 1'b0);
    push(1, 32'hA5A5_0002, 1'b1);
    tick();
    chk("single_grant", {60'd0, grant}, 64'h2);
    chk("single_size",  {52'd0, pkt_size}, 64'd8);
    tick();
    set_task(1, 1'b1, 32'hA5A5_0002, 1'b1, 12'd8);
    tick();
    set_task(1, 1'b0, 32'd0, 1'b0, 12'd0);
    chk("single_len_err", {63'd0, len_err}, 64'd0);
    chk("single_gap_valid", {63'd0, ans_ready}, 64'd0);
    tick();
    chk("single_release", {60'd0, grant}, 64'd0);
    tick();

    // ---- backpressure: task 0, size 12, manager ready 1,0,1,0,1
    set_task(0, 1'b1, 32'hC000_0001, 1'b0, 12'd12);
    tm_ready = 1'b0;
    push(0, 32'hC000_0001, 1'b0);
    push(0, 32'hC000_0002, 1'b0);
    push(0, 32'hC000_0003, 1'b1);
    tick();
    chk("bp_grant", {60'd0, grant}, 64'h1);
    tm_ready = 1'b1;
    tick();
    set_task(0, 1'b1, 32'hC000_0002, 1'b0, 12'd12);
    tm_ready = 1'b0;
    tick();
    chk("bp_hold_data", {32'd0, ans_data}, 64'hC000_0002);
    chk("bp_hold_valid", {63'd0, ans_ready}, 64'd1);
    chk("bp_tmr_low", {60'd0, tmr_o}, 64'd0);
    tm_ready = 1'b1;
    tick();
    set_task(0, 1'b1, 32'hC000_0003, 1'b1, 12'd12);
    tm_ready = 1'b0;
    tick();
    chk("bp_hold_last", {32'd0, ans_data}, 64'hC000_0003);
    tm_ready = 1'b1;
    tick();
    set_task(0, 1'b0, 32'd0, 1'b0, 12'd0);
    chk("bp_len_err", {63'd0, len_err}, 64'd0);
    tick();
    tick();

    // ---- length error: task 3, size 5, one word
    set_task(3, 1'b1, 32'hD000_0003, 1'b1, 12'd5);
    push(3, 32'hD000_0003, 1'b1);
    tick();
    chk("lerr_grant", {60'd0, grant}, 64'h8);
    chk("lerr_before", {63'd0, len_err}, 64'd0);
    tick();
    set_task(3, 1'b0, 32'd0, 1'b0, 12'd0);
    chk("lerr_set", {63'd0, len_err}, 64'd1);
    tick();
    tick();
    tick();
    chk("lerr_sticky", {63'd0, len_err}, 64'd1);

    // ---- reset mid-packet: task 2 streaming, task 0 waiting
    set_task(2, 1'b1, 32'hE000_0002, 1'b0, 12'd8);
    push(2, 32'hE000_0002, 1'b0);
    tick();
    chk("rstmid_grant", {60'd0, grant}, 64'h4);
    tick();
    set_task(2, 1'b1, 32'hE000_0012, 1'b0, 12'd8);
    set_task(0, 1'b1, 32'hF000_0000, 1'b1, 12'd4);
    tm_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_grant0",   {60'd0, grant},     64'd0);
    chk("rstmid_valid0",   {63'd0, ans_ready}, 64'd0);
    chk("rstmid_data0",    {32'd0, ans_data},  64'd0);
    chk("rstmid_size0",    {52'd0, pkt_size},  64'd0);
    chk("rstmid_len_err0", {63'd0, len_err},   64'd0);
    tick();
    rst_n    = 1'b1;
    tm_ready = 1'b1;
    push(0, 32'hF000_0000, 1'b1);
    tick();
    chk("rstmid_task0_wins", {60'd0, grant}, 64'h1);
    tick();
    req = '0;
    chk("rstmid_len_err", {63'd0, len_err}, 64'd0);
    chk("no_timeout", {63'd0, timeout}, 64'd0);
    tick();
    tick();

`ifdef TASK_ARB_TIMEOUT_EN
    // ---- timeout: task 1 stalls with task 2 pending
    set_task(1, 1'b1, 32'h1111_0001, 1'b0, 12'd8);
    set_task(2, 1'b1, 32'h2222_0002, 1'b1, 12'd4);
    push(1, 32'h1111_0001, 1'b0);
    tick();
    chk("to_grant1", {60'd0, grant}, 64'h2);
    tick();
    req[1] = 1'b0;
    for (int c = 1; c < 16; c++) begin
      chk("to_early", {63'd0, timeout}, 64'd0);
      tick();
    end
    tick();
    chk("to_pulse", {63'd0, timeout}, 64'd1);
    push(2, 32'h2222_0002, 1'b1);
    tick();
    chk("to_pulse_end", {63'd0, timeout}, 64'd0);
    tick();
    chk("to_grant2", {60'd0, grant}, 64'h4);
    tick();
    req = '0;
    chk("to_len_err", {63'd0, len_err}, 64'd0);
    tick();
    tick();
`endif

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
